// File: rtl/stream_mux_n.sv
// N:1 registered stream multiplexer, explicit-select or round-robin grant, one output register.
// Optional beat counter (xfer_cnt / clr_cnt) is built only when STREAM_MUX_CNT_EN is defined.
module stream_mux_n #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [CH_W-1:0]          sel,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch
`ifdef STREAM_MUX_CNT_EN
  ,
  input  logic                     clr_cnt,
  output logic [15:0]              xfer_cnt
`endif
);

  // Handshake: a beat moves on a port in any cycle where its valid and ready are both 1;
  // valid never waits on ready, and ready here is only raised toward a channel that is valid.
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_last_grant;

  logic              w_load_en;
  logic              w_granted;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_idx;
  logic [DATA_W-1:0] w_data;

  assign w_load_en = !r_out_valid || out_ready;

  always_comb begin
    w_granted = 1'b0;
    w_grant   = '0;
    w_idx     = '0;
    if (!mode) begin
      // Comparing against every legal index means an out-of-range sel simply never matches.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == CH_W'(i) && in_valid[i]) begin
          w_granted = 1'b1;
          w_grant   = CH_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        w_idx = CH_W'((int'(r_last_grant) + k) % NUM_CH);
        if (!w_granted && in_valid[w_idx]) begin
          w_granted = 1'b1;
          w_grant   = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == CH_W'(i)) w_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = rst_n && w_load_en && w_granted && (w_grant == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (w_load_en) begin
      if (w_granted) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_data;
        r_out_ch     <= w_grant;
        r_last_grant <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

`ifdef STREAM_MUX_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (clr_cnt) begin
      r_xfer_cnt <= '0;
    end else if (r_out_valid && out_ready && r_xfer_cnt != 16'hFFFF) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed steps plus random traffic against a queue-based reference model.
module tb_stream_mux_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [CW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic [W-1:0]   ch_data [N];
`ifdef STREAM_MUX_CNT_EN
  logic           clr_cnt;
  logic [15:0]    xfer_cnt;
`endif

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  stream_mux_n #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
`ifdef STREAM_MUX_CNT_EN
    , .clr_cnt(clr_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: pointer, output-register occupancy, beat counter, expected beats
  int              m_last;
  bit              m_ov;
  int              m_cnt;
  logic [CW+W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_ov   = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  function automatic int model_grant();
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (in_valid[2'(c)]) return c;
    end
    return -1;
  endfunction

  // driver: inputs are already set (clock low); check, advance model, cross one rising edge
  task automatic step();
    int         g;
    bit         ld;
    bit         acc;
    logic [N-1:0] er;
    #1;
    ld  = !m_ov || out_ready;
    acc = m_ov && out_ready;
    g   = rst_n ? model_grant() : -1;
    er  = (rst_n && ld && g >= 0) ? N'(1 << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov && exp_q.size() > 0) chk("out_beat", 32'({out_ch, out_data}), 32'(exp_q[0]));
`ifdef STREAM_MUX_CNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
    if (rst_n) begin
      if (acc && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ld) begin
        if (g >= 0) begin
          exp_q.push_back({2'(g), ch_data[2'(g)]});
          m_last = g;
          m_ov   = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
`ifdef STREAM_MUX_CNT_EN
      if (clr_cnt) m_cnt = 0;
      else if (acc && m_cnt != 16'hFFFF) m_cnt++;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) ch_data[i] = W'($urandom_range(0, 255));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
`ifdef STREAM_MUX_CNT_EN
    clr_cnt = 1'b0;
`endif
    rand_data();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    step();

    // first round-robin grant after reset goes to channel 0
    rst_n = 1'b1;
    #1 chk("rst_first_ready", 32'(in_ready), 32'h1);
    step();
    chk("rst_first_ch", 32'(out_ch), 32'd0);

    // explicit select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; ch_data[2] = 8'hA5;
    step();
    chk("sel_data", 32'(out_data), 32'hA5);
    chk("sel_ch", 32'(out_ch), 32'd2);
    sel = 2'd1;
    step();
    chk("sel_invalid_drain", 32'(out_valid), 32'd0);

    // park the pointer on channel 3, then round-robin with all valid
    sel = 2'd3; in_valid = 4'b1000;
    step();
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step();
      chk("rr_all_ch", 32'(out_ch), 32'(i % 4));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
      chk("rr_1010_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // backpressure: held beat stays stable, next beat loads the cycle ready returns
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; ch_data[0] = 8'h3C;
    step();
    out_ready = 1'b0; ch_data[0] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_ch", 32'(out_ch), 32'd0);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp_no_bubble_valid", 32'(out_valid), 32'd1);
    chk("bp_no_bubble_data", 32'(out_data), 32'h11);

    // mode switch keeps the pointer
    sel = 2'd3; in_valid = 4'b1000;
    step();
    mode = 1'b1; in_valid = 4'b1111;
    step(); chk("ms_rr0", 32'(out_ch), 32'd0);
    step(); chk("ms_rr1", 32'(out_ch), 32'd1);
    mode = 1'b0; sel = 2'd3;
    step(); chk("ms_sel3", 32'(out_ch), 32'd3);
    mode = 1'b1;
    step(); chk("ms_rr_after", 32'(out_ch), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = CW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end

    // reset while a beat is pending
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1; out_ready = 1'b1;

`ifdef STREAM_MUX_CNT_EN
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #1 chk("cnt_ten", 32'(xfer_cnt), 32'd10);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    #1 chk("cnt_clr_priority", 32'(xfer_cnt), 32'd0);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
